uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine between NUM_REQ independent byte sources.
- Each source offers a byte plus a 5-bit frame config over a valid/ready handshake.
- The block grants sources round-robin, latches the winner's byte and config, and drives the engine's start strobe. Start is qualified by the baud tick.
- It waits for the engine's done pulse, with a baud-tick timeout. Sits between the system bus/register layer and the transmit engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_TICKS, 4096, baud_en ticks allowed in WAIT before abort (width 16)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset
enable_i  in  1  global enable; gates new grants
req_valid_i  in  NUM_REQ  per-requester valid
req_ready_o  out  NUM_REQ  per-requester ready (one-hot or zero)
req_data_i  in  NUM_REQ*8  packed bytes, requester k at [8k+7:8k]
req_conf_i  in  NUM_REQ*5  packed configs {data_size[1:0], stop_size[1:0], parity_en}
baud_en_i  in  1  baud tick shared with the engine
tx_done_i  in  1  engine frame-complete pulse
tx_en_o  out  1  engine enable
tx_start_o  out  1  engine start strobe
tx_data_o  out  8  latched byte
tx_conf_o  out  5  latched config
grant_id_o  out  clog2(NUM_REQ)  index of current/last winner
busy_o  out  1  transfer in progress
timeout_o  out  1  one-cycle pulse on WAIT abort

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state IDLE, round-robin pointer 0.
  - All outputs 0: req_ready_o, tx_start_o, tx_en_o, tx_data_o, tx_conf_o, grant_id_o, busy_o, timeout_o.
  - Timeout counter 0.
- Reset mid-transfer drops the transfer; the aborted requester is not re-served.
- tx_en_o: enable_i registered, 1-cycle delay.
- busy_o: 1 whenever state != IDLE, combinational from state.
- IDLE:
  - When enable_i=1 and any req_valid_i bit is set, the winner is the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 in that same cycle, combinational from state, enable_i, valid and pointer. The handshake completes on valid&ready.
  - On handshake: tx_data_o/tx_conf_o latch the winner's slice, grant_id_o <= winner, timeout counter cleared, next state START.
  - Requesters must hold valid and data until ready. Deasserting valid without ready is legal; it simply drops out of arbitration.
- START:
  - tx_start_o=1, combinational from state.
  - Remains in START until a cycle with baud_en_i=1, then moves to WAIT. That cycle is the engine's sampling edge.
  - Latency from handshake to the first cycle of tx_start_o: 1 clk.
- WAIT:
  - tx_start_o=0. Timeout counter increments on each baud_en_i=1.
  - On tx_done_i=1: next state IDLE, pointer <= (grant_id_o+1) mod NUM_REQ.
  - Else, when the counter reaches TIMEOUT_TICKS-1 and baud_en_i=1: timeout_o pulses 1 cycle, next state IDLE, pointer advanced the same way.
  - tx_done_i and the timeout condition in the same cycle: done wins, no timeout_o.
- tx_done_i in IDLE or START is ignored.
- enable_i falling during START/WAIT: the current transfer completes normally; no new grant until enable_i=1 again.
- Fairness: after serving k, requester k has lowest priority. With all valid held, the grant sequence is 0,1,2,3,0,...
- tx_data_o/tx_conf_o/grant_id_o hold their values after the transfer until the next handshake.
- Illegal state encoding -> IDLE next cycle.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (Idle, Start, Wait).
  - DATA_W=8, CONF_W=5.
  - conf field bit positions (PARITY_EN_BIT=0, STOP_SIZE_LSB=1, DATA_SIZE_LSB=3).
- One sub-module, uart_rr_arbiter: combinational rotate-priority-rotate. Inputs req vector and pointer; outputs one-hot grant and encoded index.

Test Plan:
- Reset then single request: req_valid_i=4'b0100, data 8'hA5, conf 5'b11010 -> req_ready_o=4'b0100 same cycle. tx_data_o=8'hA5, tx_conf_o=5'b11010, grant_id_o=2 next cycle. tx_start_o held until the first baud_en_i, then cleared.
- All four valid continuously, tx_done_i pulsed 3 baud ticks after each start -> grants in order 0,1,2,3,0; no requester granted twice before all others have been served.
- Start qualification: baud_en_i held low 20 cycles after handshake -> tx_start_o high all 20 cycles, state stays START. baud_en_i pulse -> tx_start_o low next cycle, busy_o still 1.
- Timeout: TIMEOUT_TICKS=8, never assert tx_done_i -> timeout_o single pulse after 8th tick in WAIT, busy_o=0 next cycle, pointer advanced. Repeat with tx_done_i coincident with the 8th tick -> no timeout_o.
- enable_i dropped during WAIT with req 1 pending -> current frame completes on tx_done_i. req_ready_o stays 0 until enable_i=1, then req 1 granted.
- rst_i asserted in WAIT -> all outputs 0 next cycle, pointer 0, and a valid req 0 is granted on the first cycle after reset releases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, widths and
// frame-config field positions.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int CONF_W = 5;

    localparam int PARITY_EN_BIT = 0;
    localparam int STOP_SIZE_LSB = 1;
    localparam int DATA_SIZE_LSB = 3;

    typedef logic [1:0] state_t;

    localparam state_t Idle  = 2'd0;
    localparam state_t Start = 2'd1;
    localparam state_t Wait  = 2'd2;

    // Rebuilds a config word field by field so the layout lives in one place.
    function automatic logic [CONF_W-1:0] conf_fields(input logic [CONF_W-1:0] conf);
        return {conf[DATA_SIZE_LSB +: 2], conf[STOP_SIZE_LSB +: 2], conf[PARITY_EN_BIT]};
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by the pointer, pick the
// lowest set bit, rotate the index back.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]     pos;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W:0]     sum;

    always_comb begin
        rot = '0;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (IDX_W+1)'(i) + {1'b0, ptr_i};
            if (pos >= N_W) pos = pos - N_W;
            rot[i] = req_i[pos[IDX_W-1:0]];
        end
    end

    // Scan downward so the lowest set bit is the one that sticks.
    always_comb begin
        idx_r = '0;
        any_o = 1'b0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (rot[i]) begin
                idx_r = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, idx_r} + {1'b0, ptr_i};
        if (sum >= N_W) sum = sum - N_W;
        idx_o = sum[IDX_W-1:0];
        gnt_o = '0;
        if (any_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine between NUM_REQ byte sources: round-robin
// grant, latch byte/config, baud-qualified start, wait for done or timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ*5-1:0]       req_conf_i,
    input  logic                       baud_en_i,
    input  logic                       tx_done_i,
    output logic                       tx_en_o,
    output logic                       tx_start_o,
    output logic [7:0]                 tx_data_o,
    output logic [4:0]                 tx_conf_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] N_W      = (IDX_W+1)'(NUM_REQ);
    localparam logic [15:0]    TMO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [15:0]        cnt_q;
    logic [DATA_W-1:0]  data_q;
    logic [CONF_W-1:0]  conf_q;
    logic [IDX_W-1:0]   gid_q;
    logic               tx_en_q;
    logic               timeout_q;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gidx;
    logic               gany;
    logic               hs;
    logic               tmo_hit;
    logic               xfer_end;
    logic [IDX_W:0]     ptr_inc;
    logic [DATA_W-1:0]  sel_data;
    logic [CONF_W-1:0]  sel_conf;

    // Ready is withheld during reset so no handshake can slip through it.
    assign arb_req = (state_q == Idle && enable_i && !rst_i) ? req_valid_i : '0;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign hs       = gany;
    assign tmo_hit  = (state_q == Wait) && !tx_done_i && baud_en_i && (cnt_q == TMO_LAST);
    assign xfer_end = (state_q == Wait) && (tx_done_i || tmo_hit);

    always_comb begin
        sel_data = '0;
        sel_conf = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_data = req_data_i[k*8 +: 8];
                sel_conf = req_conf_i[k*5 +: 5];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, gid_q} + 1'b1;
        if (ptr_inc >= N_W) ptr_inc = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= Idle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = Idle;
        case (state_q)
            Idle:    state_d = hs ? Start : Idle;
            Start:   state_d = baud_en_i ? Wait : Start;
            Wait:    state_d = xfer_end ? Idle : Wait;
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != Idle);
        tx_start_o = (state_q == Start);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            conf_q    <= '0;
            gid_q     <= '0;
            tx_en_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tx_en_q   <= enable_i;
            timeout_q <= tmo_hit;
            if (hs) begin
                data_q <= sel_data;
                conf_q <= conf_fields(sel_conf);
                gid_q  <= gidx;
                cnt_q  <= '0;
            end else if (state_q == Wait && baud_en_i) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (xfer_end) ptr_q <= ptr_inc[IDX_W-1:0];
        end
    end

    assign req_ready_o = gnt;
    assign tx_en_o     = tx_en_q;
    assign tx_data_o   = data_q;
    assign tx_conf_o   = conf_q;
    assign grant_id_o  = gid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and an 8-tick timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [19:0] req_conf;
    logic        baud_en;
    logic        tx_done;
    logic        tx_en;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [4:0]  tx_conf;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .TIMEOUT_TICKS (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_conf_i  (req_conf),
        .baud_en_i   (baud_en),
        .tx_done_i   (tx_done),
        .tx_en_o     (tx_en),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_conf_o   (tx_conf),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transfer from IDLE with all requests held; expects requester exp_id.
    task automatic serve(input int exp_id);
        #1;
        chk("rr_ready", {28'd0, req_ready}, 32'd1 << exp_id);
        step();
        chk("rr_gid", {30'd0, grant_id}, exp_id);
        chk("rr_data", {24'd0, tx_data}, 32'h11 * (exp_id + 1));
        chk("rr_ready_busy", {28'd0, req_ready}, 32'd0);
        baud_en = 1'b1;
        step();
        baud_en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            baud_en = 1'b1;
            step();
            baud_en = 1'b0;
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("rr_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; req_conf = '0;
        baud_en = 1'b0; tx_done = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_start", {31'd0, tx_start}, 0);
        chk("rst_en", {31'd0, tx_en}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_conf", {27'd0, tx_conf}, 0);
        chk("rst_gid", {30'd0, grant_id}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);

        // Single request on requester 2, then start held while baud_en stays low.
        enable = 1'b1;
        step();
        chk("en_delay", {31'd0, tx_en}, 1);
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        req_conf  = 20'(5'b11010) << 10;
        #1;
        chk("single_ready", {28'd0, req_ready}, 32'b0100);
        step();
        req_valid = '0;
        chk("single_data", {24'd0, tx_data}, 32'hA5);
        chk("single_conf", {27'd0, tx_conf}, 32'b11010);
        chk("single_gid", {30'd0, grant_id}, 2);
        for (int c = 0; c < 20; c++) begin
            chk("start_held", {31'd0, tx_start}, 1);
            step();
        end
        baud_en = 1'b1;
        step();
        baud_en = 1'b0;
        chk("start_cleared", {31'd0, tx_start}, 0);
        chk("wait_busy", {31'd0, busy}, 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("done_idle", {31'd0, busy}, 0);
        chk("data_hold", {24'd0, tx_data}, 32'hA5);

        // Fairness from pointer 0 with every requester valid.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        serve(0);
        serve(1);
        serve(2);
        serve(3);
        serve(0);
        req_valid = '0;

        // Timeout: pointer is 1, only requester 0 valid.
        req_valid = 4'b0001;
        #1;
        chk("tmo_ready", {28'd0, req_ready}, 32'b0001);
        step();
        req_valid = '0;
        baud_en = 1'b1;
        step();
        for (int t = 1; t < 8; t++) begin
            step();
            chk("tmo_early", {31'd0, timeout}, 0);
        end
        step();
        baud_en = 1'b0;
        chk("tmo_pulse", {31'd0, timeout}, 1);
        chk("tmo_busy", {31'd0, busy}, 0);
        step();
        chk("tmo_single", {31'd0, timeout}, 0);
        req_valid = 4'b0011;
        #1;
        chk("tmo_ptr", {28'd0, req_ready}, 32'b0010);

        // Done coincident with the 8th tick wins over the timeout.
        step();
        req_valid = '0;
        baud_en = 1'b1;
        step();
        for (int t = 1; t < 8; t++) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        baud_en = 1'b0;
        chk("coinc_no_tmo", {31'd0, timeout}, 0);
        chk("coinc_busy", {31'd0, busy}, 0);
        step();
        chk("coinc_no_tmo2", {31'd0, timeout}, 0);

        // Enable dropped during WAIT with requester 1 pending (pointer now 2).
        req_valid = 4'b0100;
        #1;
        chk("en_grant2", {28'd0, req_ready}, 32'b0100);
        step();
        req_valid = 4'b0010;
        baud_en = 1'b1;
        step();
        baud_en = 1'b0;
        enable = 1'b0;
        step();
        chk("en_wait_busy", {31'd0, busy}, 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("en_done_idle", {31'd0, busy}, 0);
        for (int c = 0; c < 3; c++) begin
            chk("en_no_ready", {28'd0, req_ready}, 0);
            step();
        end
        chk("en_txen_low", {31'd0, tx_en}, 0);
        enable = 1'b1;
        #1;
        chk("en_resume", {28'd0, req_ready}, 32'b0010);
        step();
        req_valid = '0;
        chk("en_gid", {30'd0, grant_id}, 1);

        // Reset while in WAIT; pointer must return to 0.
        baud_en = 1'b1;
        step();
        baud_en = 1'b0;
        chk("rw_busy", {31'd0, busy}, 1);
        req_valid = 4'b1001;
        rst = 1'b1;
        step();
        chk("rw_ready", {28'd0, req_ready}, 0);
        chk("rw_busy0", {31'd0, busy}, 0);
        chk("rw_start", {31'd0, tx_start}, 0);
        chk("rw_data", {24'd0, tx_data}, 0);
        chk("rw_gid", {30'd0, grant_id}, 0);
        chk("rw_en", {31'd0, tx_en}, 0);
        rst = 1'b0;
        #1;
        chk("rw_grant0", {28'd0, req_ready}, 32'b0001);
        step();
        chk("rw_gid0", {30'd0, grant_id}, 0);
        chk("rw_start1", {31'd0, tx_start}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
